// File: rtl/unidade_controle.sv
`timescale 1ns/1ps
// Multicycle control unit: fetch, decode, execute, memory, write-back and PC update
// sequencing for a small RISC-V subset, with a memory-wait watchdog and a retire counter.
module unidade_controle #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        imm_sinal,
    input  logic        zero,
    input  logic        mem_pronto,
    output logic [3:0]  estado,
    output logic        pcsrc,
    output logic        negativo,
    output logic        memread,
    output logic        memwrite,
    output logic        ir_write,
    output logic        regwrite,
    output logic        alusrc,
    output logic        memtoreg,
    output logic [1:0]  aluop,
    output logic        erro,
    output logic [31:0] instr_count
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        StBusca      = 4'b0000,
        StDecodifica = 4'b0001,
        StExecuta    = 4'b0010,
        StMemoria    = 4'b0011,
        StEscrita    = 4'b0100,
        StAtualizaPc = 4'b1000,
        StErro       = 4'b1111
    } estado_t;

    estado_t       state;
    logic [6:0]    op_q;
    logic [2:0]    f3_q;
    logic [CW-1:0] wait_cnt;

    logic is_r, is_i, is_load, is_store, is_branch, timeout_hit;

    // Decode of the opcode latched in DECODIFICA; only meaningful from EXECUTA onwards.
    assign is_r        = (op_q == OpR);
    assign is_i        = (op_q == OpI);
    assign is_load     = (op_q == OpLoad);
    assign is_store    = (op_q == OpStore);
    assign is_branch   = (op_q == OpBranch);
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
    assign estado      = state;

    function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
        unique case (op)
            OpR, OpI, OpLoad, OpStore: legal = 1'b1;
            OpBranch:                  legal = (f3 == 3'b000) || (f3 == 3'b001);
            default:                   legal = 1'b0;
        endcase
    endfunction

    // State sequencing plus all registered outputs, latched opcode and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StBusca;
            pcsrc       <= 1'b0;
            negativo    <= 1'b0;
            erro        <= 1'b0;
            instr_count <= '0;
            wait_cnt    <= '0;
            op_q        <= '0;
            f3_q        <= '0;
        end else begin
            unique case (state)
                StBusca, StMemoria: begin
                    if (mem_pronto) begin
                        // A ready on the timeout cycle still wins.
                        wait_cnt <= '0;
                        if (state == StBusca) state <= StDecodifica;
                        else if (is_load)     state <= StEscrita;
                        else                  state <= StAtualizaPc;
                    end else if (timeout_hit) begin
                        wait_cnt <= '0;
                        state    <= StErro;
                        erro     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                StDecodifica: begin
                    op_q <= opcode;
                    f3_q <= funct3;
                    if (legal(opcode, funct3)) begin
                        state <= StExecuta;
                    end else begin
                        state <= StErro;
                        erro  <= 1'b1;
                    end
                end
                StExecuta: begin
                    if (is_branch) begin
                        pcsrc    <= ((f3_q == 3'b000) && zero) || ((f3_q == 3'b001) && !zero);
                        negativo <= imm_sinal;
                        state    <= StAtualizaPc;
                    end else if (is_r || is_i) begin
                        state <= StEscrita;
                    end else if (is_load || is_store) begin
                        state <= StMemoria;
                    end else begin
                        state <= StErro;
                        erro  <= 1'b1;
                    end
                end
                StEscrita: state <= StAtualizaPc;
                StAtualizaPc: begin
                    instr_count <= instr_count + 32'd1;
                    pcsrc       <= 1'b0;
                    negativo    <= 1'b0;
                    state       <= StBusca;
                end
                StErro: state <= StErro;
                default: begin
                    state <= StErro;
                    erro  <= 1'b1;
                end
            endcase
        end
    end

    // Combinational strobes decoded from the current state and latched opcode.
    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        ir_write = 1'b0;
        regwrite = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        aluop    = 2'b00;
        unique case (state)
            StBusca: begin
                memread  = 1'b1;
                ir_write = mem_pronto;
            end
            StExecuta: begin
                if (is_r) begin
                    aluop = 2'b10;
                end else if (is_i) begin
                    aluop  = 2'b10;
                    alusrc = 1'b1;
                end else if (is_load || is_store) begin
                    alusrc = 1'b1;
                end else if (is_branch) begin
                    aluop = 2'b01;
                end
            end
            StMemoria: begin
                memread  = is_load;
                memwrite = is_store;
            end
            StEscrita: begin
                regwrite = 1'b1;
                memtoreg = is_load;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
`timescale 1ns/1ps
// Randomized bench: a driver issues instructions on a schedule it computes itself,
// pushes the expected retire record, and a monitor checks it when estado shows 1000.
module tb_unidade_controle;

    localparam int unsigned TO = 15;
    localparam int NINSTR = 60;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        imm_sinal, zero, mem_pronto;
    logic [3:0]  estado;
    logic        pcsrc, negativo, memread, memwrite, ir_write, regwrite, alusrc, memtoreg;
    logic [1:0]  aluop;
    logic        erro;
    logic [31:0] instr_count;

    unidade_controle #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .imm_sinal(imm_sinal),
        .zero(zero), .mem_pronto(mem_pronto), .estado(estado), .pcsrc(pcsrc),
        .negativo(negativo), .memread(memread), .memwrite(memwrite), .ir_write(ir_write),
        .regwrite(regwrite), .alusrc(alusrc), .memtoreg(memtoreg), .aluop(aluop),
        .erro(erro), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [31:0] retired = '0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        pcsrc;
        logic        neg;
        logic [31:0] cnt;
        int          cyc;
        int          rw;
        int          mtr;
        int          mr;
        int          mw;
        int          ir;
        logic [1:0]  aluop;
        logic        alusrc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic mp);
        mem_pronto = mp;
        @(posedge clk);
        #1;
    endtask

    // Reference: an instruction is a sequence of phases with known lengths; the expected
    // retire cycle and strobe tallies follow from the instruction class and wait counts.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic imm,
                             input logic z, input int fw, input int mw);
        exp_t e;
        bit is_ld, is_st, is_br, is_alu, has_mem, has_wb;
        is_ld   = (opc == LD_OP);
        is_st   = (opc == ST_OP);
        is_br   = (opc == BR_OP);
        is_alu  = (opc == R_OP) || (opc == I_OP);
        has_mem = is_ld || is_st;
        has_wb  = is_alu || is_ld;
        e.pcsrc  = is_br && (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z));
        e.neg    = is_br && imm;
        e.cnt    = retired;
        e.cyc    = cyc + fw + 3 + (has_mem ? mw + 1 : 0) + (has_wb ? 1 : 0);
        e.rw     = has_wb ? 1 : 0;
        e.mtr    = is_ld ? 1 : 0;
        e.mr     = fw + 1 + (is_ld ? mw + 1 : 0);
        e.mw     = is_st ? mw + 1 : 0;
        e.ir     = 1;
        e.aluop  = is_alu ? 2'b10 : (is_br ? 2'b01 : 2'b00);
        e.alusrc = (opc == I_OP) || has_mem;
        sb.push_back(e);
        retired = retired + 32'd1;
        opcode = opc; funct3 = f3; imm_sinal = imm; zero = z;
        for (int i = 0; i < fw; i++) step(1'b0);
        step(1'b1);
        step(1'($urandom_range(0, 1)));
        step(1'($urandom_range(0, 1)));
        if (has_mem) begin
            for (int i = 0; i < mw; i++) step(1'b0);
            step(1'b1);
        end
        if (has_wb) step(1'($urandom_range(0, 1)));
        step(1'($urandom_range(0, 1)));
    endtask

    // Monitor: tallies strobes per instruction and checks a record at each retire.
    int rw_s = 0, mtr_s = 0, mr_s = 0, mw_s = 0, ir_s = 0;
    logic [1:0] alu_s = 2'b11;
    logic alusrc_s = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                rw_s  += int'(regwrite);
                mtr_s += int'(memtoreg);
                mr_s  += int'(memread);
                mw_s  += int'(memwrite);
                ir_s  += int'(ir_write);
                if (estado == 4'b0010) begin
                    alu_s    = aluop;
                    alusrc_s = alusrc;
                end
                if (estado == 4'b1000) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL retire: got unexpected retire, expected none queued");
                    end else begin
                        e = sb.pop_front();
                        check("retire_cycle", 32'(cyc), 32'(e.cyc));
                        check("pcsrc", 32'(pcsrc), 32'(e.pcsrc));
                        check("negativo", 32'(negativo), 32'(e.neg));
                        check("instr_count", instr_count, e.cnt);
                        check("regwrite_cycles", 32'(rw_s), 32'(e.rw));
                        check("memtoreg_cycles", 32'(mtr_s), 32'(e.mtr));
                        check("memread_cycles", 32'(mr_s), 32'(e.mr));
                        check("memwrite_cycles", 32'(mw_s), 32'(e.mw));
                        check("ir_write_cycles", 32'(ir_s), 32'(e.ir));
                        check("aluop", 32'(alu_s), 32'(e.aluop));
                        check("alusrc", 32'(alusrc_s), 32'(e.alusrc));
                        check("erro_retire", 32'(erro), 32'd0);
                    end
                    rw_s = 0; mtr_s = 0; mr_s = 0; mw_s = 0; ir_s = 0;
                    alu_s = 2'b11; alusrc_s = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_estado", 32'(estado), 32'h0);
        check("rst_erro", 32'(erro), 32'd0);
        check("rst_count", instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [5];
        int k, fw, mw;
        logic [2:0] f3;
        ops[0] = R_OP; ops[1] = I_OP; ops[2] = LD_OP; ops[3] = ST_OP; ops[4] = BR_OP;
        rst_n = 1'b0; opcode = '0; funct3 = '0; imm_sinal = 1'b0; zero = 1'b0;
        mem_pronto = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_estado", 32'(estado), 32'h0);
        check("reset_erro", 32'(erro), 32'd0);
        check("reset_count", instr_count, 32'd0);
        check("reset_pcsrc", 32'(pcsrc), 32'd0);
        check("reset_negativo", 32'(negativo), 32'd0);
        check("reset_memread", 32'(memread), 32'd1);
        rst_n = 1'b1;

        // Random legal instruction stream, occasionally waiting right up to the timeout.
        mon_en = 1'b1;
        for (int n = 0; n < NINSTR; n++) begin
            k  = int'($urandom_range(0, 4));
            f3 = (k == 4) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            fw = ($urandom_range(0, 9) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 3));
            run_instr(ops[k], f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fw, mw);
        end
        // Directed branch and load cases.
        run_instr(BR_OP, 3'd0, 1'b1, 1'b1, 0, 0);
        run_instr(BR_OP, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(BR_OP, 3'd1, 1'b0, 1'b0, 0, 0);
        run_instr(LD_OP, 3'd2, 1'b0, 1'b0, 0, 3);
        run_instr(R_OP, 3'd0, 1'b0, 1'b0, 0, 0);
        mon_en = 1'b0;
        check("queue_drained", 32'(sb.size()), 32'd0);
        check("final_count", instr_count, retired);
        check("final_estado", 32'(estado), 32'h0);

        // Asynchronous reset in the middle of a STORE memory phase.
        opcode = ST_OP; funct3 = 3'd2;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        #2;
        check("store_mem_estado", 32'(estado), 32'h3);
        check("store_memwrite", 32'(memwrite), 32'd1);
        check("store_count", instr_count, retired);
        rst_n = 1'b0;
        #1;
        check("async_estado", 32'(estado), 32'h0);
        check("async_memwrite", 32'(memwrite), 32'd0);
        check("async_count", instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Illegal opcode: decode then error, sticky.
        opcode = 7'b1111111; funct3 = 3'd0;
        step(1'b1);
        check("illegal_dec", 32'(estado), 32'h1);
        step(1'b1);
        check("illegal_estado", 32'(estado), 32'hF);
        check("illegal_erro", 32'(erro), 32'd1);
        check("illegal_count", instr_count, 32'd0);
        check("illegal_memread", 32'(memread), 32'd0);
        check("illegal_ir_write", 32'(ir_write), 32'd0);
        repeat (3) step(1'b1);
        check("illegal_sticky", 32'(estado), 32'hF);
        do_reset();

        // Branch with an unsupported funct3.
        opcode = BR_OP; funct3 = 3'b010;
        step(1'b1);
        step(1'b0);
        check("bad_branch_estado", 32'(estado), 32'hF);
        do_reset();

        // Fetch timeout: TIMEOUT waiting cycles lead to ERRO.
        opcode = R_OP; funct3 = 3'd0;
        for (int i = 0; i < int'(TO) - 1; i++) step(1'b0);
        check("fetch_wait_estado", 32'(estado), 32'h0);
        check("fetch_wait_erro", 32'(erro), 32'd0);
        step(1'b0);
        check("fetch_timeout_estado", 32'(estado), 32'hF);
        check("fetch_timeout_erro", 32'(erro), 32'd1);
        repeat (4) step(1'b1);
        check("timeout_sticky", 32'(erro), 32'd1);
        do_reset();

        // Memory-phase timeout on a LOAD.
        opcode = LD_OP; funct3 = 3'd2;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < int'(TO) - 1; i++) step(1'b0);
        check("mem_wait_estado", 32'(estado), 32'h3);
        check("mem_wait_memread", 32'(memread), 32'd1);
        step(1'b0);
        check("mem_timeout_estado", 32'(estado), 32'hF);
        check("mem_timeout_erro", 32'(erro), 32'd1);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
